// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          DEF_BUF_DEPTH = 2;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding {instr, pc} pairs between instruction memory and decode.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);
    logic [31:0] instr_mem [2];
    logic [31:0] pc_mem [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload slots carry no reset; occupancy alone decides what is valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == 1'(gi))) begin
                    instr_mem[gi] <= push_instr;
                    pc_mem[gi]    <= push_pc;
                end
            end
        end
    endgenerate

    assign head_instr = instr_mem[rd_ptr_q];
    assign head_pc    = pc_mem[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request issue, response buffering and redirect flushing.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_src,
    input  logic [31:0] PC_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);
    localparam logic [2:0] DEPTH_LIM = 3'(BUF_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_ptr_q, fetch_ptr_d;
    logic [1:0]   outstanding_q, outstanding_d;
    logic [1:0]   discard_q, discard_d;
    logic         fault_q, fault_d;

    logic         buf_push, buf_pop, buf_clear, buf_full, buf_empty;
    logic [1:0]   buf_count;
    logic [31:0]  head_instr, head_pc, redir_target;
    logic [2:0]   in_flight;
    logic         grant, rsp, accept, redirect, misaligned;

    // Buffered entries plus outstanding grants never exceed the buffer size.
    assign in_flight   = {1'b0, buf_count} + {1'b0, outstanding_q};
    assign imem_req    = (state_q == ST_RUN) && (in_flight < DEPTH_LIM);
    assign imem_addr   = fetch_ptr_q;
    assign grant       = imem_req & imem_gnt;
    assign rsp         = imem_rvalid & (outstanding_q != 2'd0);
    assign instr_valid = ~buf_empty;
    assign accept      = instr_valid & instr_ready;
    assign redirect    = PC_src & accept;
    assign instr       = buf_empty ? NOP_INSTR : head_instr;
    assign PC          = buf_empty ? RESET_PC : head_pc;
    assign PC_plus4    = PC + 32'd4;
    assign fetch_fault = fault_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_target = PC_target;
    assign misaligned   = redirect & (PC_target[1:0] != 2'b00);
`else
    assign redir_target = PC_target & 32'hFFFF_FFFC;
    assign misaligned   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        fetch_ptr_d   = fetch_ptr_q;
        outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, rsp};
        discard_d     = discard_q;
        fault_d       = fault_q;
        buf_push      = 1'b0;
        buf_pop       = accept;
        buf_clear     = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (grant) fetch_ptr_d = fetch_ptr_q + 32'd4;
                if (redirect) begin
                    // A same-cycle response is dropped; a same-cycle grant is waited out.
                    buf_clear   = 1'b1;
                    fetch_ptr_d = redir_target;
                    discard_d   = outstanding_d;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else if (outstanding_d != 2'd0) begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    buf_push = rsp & ~buf_full;
                end
            end
            ST_FLUSH: begin
                if (rsp && discard_q != 2'd0) discard_d = discard_q - 2'd1;
                if (discard_q == 2'd0 || (rsp && discard_q == 2'd1)) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            fetch_ptr_q   <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_ptr_q   <= fetch_ptr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fault_q       <= fault_d;
        end
    end

    fetch_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (buf_clear),
        .push       (buf_push),
        .push_instr (imem_rdata),
        .push_pc    (fetch_ptr_q - {outstanding_q, 2'b00}),
        .pop        (buf_pop),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: startup table, directed corner sequences, randomized run.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_src;
    logic [31:0] PC_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .PC_src(PC_src), .PC_target(PC_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .PC(PC), .PC_plus4(PC_plus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_fault(fetch_fault)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic rdy; logic gnt;
        logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_pc;
    } vec_t;

    mreq_t       mem_q[$];
    vec_t        vecs[8];
    int          n_checks = 0, n_pass = 0, n_grants = 0, n_acc = 0, cyc = 0;
    int          gnt_mode = 0, rdy_mode = 0, lat_min = 1, lat_max = 1, src_pct = 0;
    logic [31:0] exp_pc = RST_PC;
    bit          halted = 0, prev_pending = 0, prev_hold = 0;
    logic [31:0] prev_addr, prev_pc, prev_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Transaction-level observation of one cycle: memory model, ordering scoreboard, protocol rules.
    task automatic observe();
        logic acc, redir;
        acc   = instr_valid & instr_ready;
        redir = acc & PC_src;
        check("fault_flag", {31'b0, fetch_fault}, {31'b0, halted});
        if (halted) begin
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, instr_valid}, 32'd0);
        end
        if (prev_pending) begin
            check("req_hold", {31'b0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, prev_addr);
        end
        if (prev_hold) begin
            check("valid_hold", {31'b0, instr_valid}, 32'd1);
            check("pc_hold", PC, prev_pc);
            check("instr_hold", instr, prev_instr);
        end
        if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            mem_q.push_back('{imem_addr, cyc + $urandom_range(lat_min, lat_max)});
            n_grants++;
            check("inflight_bound", {31'b0, (mem_q.size() + int'(instr_valid)) <= 2}, 32'd1);
            check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
        end
        if (acc) begin
            $display("accept cyc=%0d pc=%h instr=%h redirect=%0d", cyc, PC, instr, redir);
            n_acc++;
            check("pc", PC, exp_pc);
            check("instr", instr, mem_word(exp_pc));
            check("pc_plus4", PC_plus4, exp_pc + 32'd4);
            if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (PC_target[1:0] != 2'b00) halted = 1;
                else exp_pc = PC_target;
`else
                exp_pc = PC_target & 32'hFFFF_FFFC;
`endif
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        prev_pending = imem_req & ~imem_gnt & ~redir;
        prev_addr    = imem_addr;
        prev_hold    = instr_valid & ~instr_ready;
        prev_pc      = PC;
        prev_instr   = instr;
    endtask

    task automatic drive_next();
        imem_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : ($urandom_range(0, 99) < 70);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
        instr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 99) < 70);
        if (src_pct > 0 && $urandom_range(0, 99) < src_pct) begin
            PC_src    = 1'b1;
            PC_target = 32'h1000 + ($urandom_range(0, 63) << 2);
`ifndef FETCH_MISALIGN_TRAP_EN
            PC_target = PC_target + $urandom_range(0, 3);
`endif
        end else begin
            PC_src    = 1'b0;
            PC_target = $urandom();
        end
    endtask

    task automatic half1(); @(negedge clk); observe(); endtask
    task automatic half2(); @(posedge clk); cyc++; #1; drive_next(); endtask
    task automatic tick(); half1(); half2(); endtask

    // Asserts rst mid-cycle, checks the asynchronous reset outputs, releases just after an edge.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", PC, RST_PC);
        check("rst_pc_plus4", PC_plus4, RST_PC + 32'd4);
        mem_q.delete();
        exp_pc = RST_PC; halted = 0; prev_pending = 0; prev_hold = 0;
        PC_src = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        drive_next();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bit fired = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            if (instr_valid && imem_req) begin
                PC_src = 1'b1; PC_target = tgt; instr_ready = 1'b1; fired = 1;
            end
            tick();
        end
        check("redirect_fired", {31'b0, fired}, 32'd1);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp);
        int i = 0;
        while (!instr_valid && i < 30) begin tick(); i++; end
        check(name, instr_valid ? PC : 32'hFFFF_FFFF, exp);
    endtask

    initial begin
        rst = 1'b1; PC_src = 1'b0; PC_target = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

        // Always-grant, 1-cycle memory, decode always ready; cycle k counted from reset release.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};

        apply_reset();
        for (int k = 0; k < 8; k++) begin
            instr_ready = vecs[k].rdy;
            imem_gnt    = vecs[k].gnt;
            half1();
            check($sformatf("tbl%0d_req", k), {31'b0, imem_req}, {31'b0, vecs[k].exp_req});
            if (vecs[k].exp_req) check($sformatf("tbl%0d_addr", k), imem_addr, vecs[k].exp_addr);
            check($sformatf("tbl%0d_valid", k), {31'b0, instr_valid}, {31'b0, vecs[k].exp_valid});
            if (vecs[k].exp_valid) check($sformatf("tbl%0d_pc", k), PC, vecs[k].exp_pc);
            half2();
        end

        // Decode stalls: buffer fills, requests stop, head held.
        begin
            int g0;
            rdy_mode = 1; instr_ready = 1'b0; g0 = n_grants;
            repeat (5) tick();
            half1();
            check("stall_grants", {31'b0, (n_grants - g0) <= 2}, 32'd1);
            check("stall_full_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_full_req", {31'b0, imem_req}, 32'd0);
            half2();
            rdy_mode = 0; instr_ready = 1'b1;
            repeat (10) tick();
        end

        // Redirect with a grant in flight: FLUSH drops it, refetch from target.
        lat_min = 3; lat_max = 3;
        rdy_mode = 1; instr_ready = 1'b0;
        repeat (8) tick();
        rdy_mode = 0; instr_ready = 1'b1;
        redirect_to(32'h0000_0100);
        half1(); check("flush_req", {31'b0, imem_req}, 32'd0); half2();
        wait_valid("redirect_pc", 32'h0000_0100);

        // Grant withheld: request and address stay put.
        begin
            logic [31:0] a0;
            gnt_mode = 1;
            repeat (6) tick();
            a0 = imem_addr;
            for (int i = 0; i < 3; i++) begin
                half1();
                check("nogrant_req", {31'b0, imem_req}, 32'd1);
                check("nogrant_addr", imem_addr, a0);
                half2();
            end
            gnt_mode = 0;
            repeat (6) tick();
        end

        // Misaligned redirect.
        rdy_mode = 1; instr_ready = 1'b0;
        repeat (8) tick();
        rdy_mode = 0; instr_ready = 1'b1;
        redirect_to(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (6) tick();
        half1();
        check("trap_fault", {31'b0, fetch_fault}, 32'd1);
        check("trap_req", {31'b0, imem_req}, 32'd0);
        half2();
        apply_reset();
`else
        wait_valid("misalign_forced_pc", 32'h0000_0100);
`endif

        // Reset pulse while flushing: refetch from the reset address.
        rdy_mode = 1; instr_ready = 1'b0;
        repeat (8) tick();
        rdy_mode = 0; instr_ready = 1'b1;
        redirect_to(32'h0000_0200);
        half1(); check("flush_req2", {31'b0, imem_req}, 32'd0); half2();
        apply_reset();
        wait_valid("refetch_pc", RST_PC);

        // Randomized run against the ordering scoreboard.
        gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 3; src_pct = 15;
        begin
            int a0 = n_acc;
            repeat (1500) tick();
            check("progress", {31'b0, (n_acc - a0) > 100}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
